// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle main control FSM driving datapath enables, mux selects and ALUOp; CTRL_ADDI_EN adds the addi path
module main_control_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic [1:0] ALUOp,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       PCEn,
  output logic [3:0] State
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd11;
`ifdef CTRL_ADDI_EN
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
`endif
  logic [3:0]  state, next_state;
  logic [14:0] ctrl;
  // state register; reset always returns to FETCH
  always_ff @(posedge CLK) begin
    if (RST) state <= FETCH;
    else     state <= next_state;
  end
  // next-state logic; unknown opcodes and illegal codes fall back to FETCH
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE:
        case (Opcode)
          6'b100011, 6'b101011: next_state = MEMADR;
          6'b000000:            next_state = EXECUTE;
          6'b000100:            next_state = BRANCH;
          6'b000010:            next_state = JUMP;
`ifdef CTRL_ADDI_EN
          6'b001000:            next_state = ADDIEXEC;
`endif
          default:              next_state = FETCH;
        endcase
      MEMADR:   next_state = (Opcode == 6'b101011) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWB;
      EXECUTE:  next_state = ALUWB;
`ifdef CTRL_ADDI_EN
      ADDIEXEC: next_state = ADDIWB;
`endif
      default:  next_state = FETCH;
    endcase
  end
  // Moore decode: {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, IRWrite, MemWrite, RegWrite, PCWrite, Branch, ALUOp}
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH:    ctrl = 15'b0000_01_00_1_0_0_1_0_00;
      DECODE:   ctrl = 15'b0000_11_00_0_0_0_0_0_00;
      MEMADR:   ctrl = 15'b0100_10_00_0_0_0_0_0_00;
      MEMREAD:  ctrl = 15'b1000_00_00_0_0_0_0_0_00;
      MEMWB:    ctrl = 15'b0001_00_00_0_0_1_0_0_00;
      MEMWRITE: ctrl = 15'b1000_00_00_0_1_0_0_0_00;
      EXECUTE:  ctrl = 15'b0100_00_00_0_0_0_0_0_10;
      ALUWB:    ctrl = 15'b0010_00_00_0_0_1_0_0_00;
      BRANCH:   ctrl = 15'b0100_00_01_0_0_0_0_1_01;
`ifdef CTRL_ADDI_EN
      ADDIEXEC: ctrl = 15'b0100_10_00_0_0_0_0_0_00;
      ADDIWB:   ctrl = 15'b0000_00_00_0_0_1_0_0_00;
`endif
      JUMP:     ctrl = 15'b0000_00_10_0_0_0_1_0_00;
      default:  ctrl = '0;
    endcase
  end
  assign {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, IRWrite, MemWrite, RegWrite, PCWrite, Branch, ALUOp} = RST ? '0 : ctrl;
  assign State = RST ? '0 : state;
  assign PCEn  = ~RST & (ctrl[3] | (ctrl[2] & Zero));
endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control state machine: the producer of the 2-bit ALUOp code that the ALU decoder consumes. One instruction executes over 3–5 cycles: fetch, decode, then an opcode-specific path. The block drives every datapath enable and mux select for that sequence, and PCEn for the program-counter register. It sits beside the ALU decoder in the control unit and takes Opcode from the instruction register.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- Opcode  in  6  instr[31:26] from the instruction register; sampled only in DECODE
- Zero  in  1  ALU zero flag
- ALUOp  out  2  to the ALU decoder: 00 add, 01 subtract, 10 use Funct
- IorD, ALUSrcA, RegDst, MemtoReg  out  1 each  datapath mux selects
- ALUSrcB, PCSrc  out  2 each  datapath mux selects
- IRWrite, MemWrite, RegWrite, PCWrite, Branch  out  1 each  enables
- PCEn  out  1  PCWrite | (Branch & Zero)
- State  out  4  current state, for debug and verification

## Operation
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11
  - Codes 12–15 are illegal.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by Opcode: 100011 or 101011 → MEMADR; 000000 → EXECUTE; 000100 → BRANCH; 001000 → ADDIEXEC; 000010 → JUMP; any other value → FETCH, executed as a NOP.
  - MEMADR: → MEMREAD for lw, → MEMWRITE for sw. Decided on Opcode, which the instruction register holds stable.
  - MEMREAD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEXEC → ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
  - Illegal codes → FETCH.
- Moore outputs, decoded from State only. Any output not listed for a state is 0:
  - FETCH: ALUSrcB=01, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMREAD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWRITE: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
  - Illegal states: all outputs 0.
- PCEn is combinational. Zero is used only while in BRANCH.

## Timing
- Reset:
  - RST high at a rising edge loads State=FETCH.
  - While RST is high, every output is forced to 0, PCEn included. This overrides state decode.
  - Reset asserted mid-instruction aborts it; no write enable asserts during the reset cycle.
- The first cycle after RST deasserts is FETCH with IRWrite=PCWrite=1.
- Instruction latency in cycles, including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- Each state lasts exactly one cycle. There are no stalls and no handshakes.
- Outputs change only after a clock edge, except PCEn, which follows Zero within the BRANCH cycle.

## Configuration
- Macro: CTRL_ADDI_EN.
- Defined: opcode 001000 takes DECODE → ADDIEXEC → ADDIWB → FETCH.
- Undefined:
  - Opcode 001000 is an unknown opcode (DECODE → FETCH).
  - Codes 9 and 10 are illegal states: all outputs 0, next state FETCH.
  - No ADDIEXEC or ADDIWB decode logic is compiled.

## Test plan
- Reset and lw: hold RST for 2 cycles with Opcode=100011. During reset all outputs are 0. After release, State follows 0,1,2,3,4,0. MEMWB shows MemtoReg=1, RegWrite=1.
- R-type: Opcode=000000 → State 0,1,6,7,0. ALUOp=10 only in state 6. RegDst=1 and RegWrite=1 in state 7.
- beq:
  - Opcode=000100, Zero=1 in BRANCH → PCEn=1, PCSrc=01, ALUOp=01.
  - Repeat with Zero=0 → PCEn=0.
- sw and j:
  - sw: Opcode=101011 → 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5.
  - j: Opcode=000010 → 0,1,11,0. PCWrite=1 and PCSrc=10 in state 11.
- Unknown opcode and macro:
  - Opcode=111111 → 0,1,0.
  - Opcode=001000 with CTRL_ADDI_EN → 0,1,9,10,0. ADDIWB shows RegWrite=1, RegDst=0.
  - Opcode=001000 without CTRL_ADDI_EN → 0,1,0.
- Reset mid-instruction: assert RST in MEMREAD (State=3) → all outputs 0 that cycle, State=0 at the next edge, no RegWrite pulse.
